// File: rtl/cordic_pkg.sv
// Shared constants, direction encoding and FSM state type for the CORDIC x/y rotator.
package cordic_pkg;

  localparam int CORDIC_ITER   = 8;
  localparam int CORDIC_K_INIT = 155;
  localparam int CORDIC_DATA_W = 10;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_xy_rotator_if.sv
// Control/result bundle between the angle-convergence stage and the x/y rotator.
interface cordic_xy_rotator_if #(
  parameter int DATA_W = 10
) ();

  logic                     START;
  logic                     STEP_VALID;
  logic                     DIR;
  logic signed [DATA_W-1:0] COS;
  logic signed [DATA_W-1:0] SIN;
  logic                     BUSY;
  logic                     DONE;

  modport master (
    output START, STEP_VALID, DIR,
    input  COS, SIN, BUSY, DONE
  );

  modport slave (
    input  START, STEP_VALID, DIR,
    output COS, SIN, BUSY, DONE
  );

endinterface

// File: rtl/cordic_xy_step.sv
// One combinational CORDIC micro-rotation on (X, Y) with arithmetic-shift operands.
// Define CORDIC_XY_SAT_EN to clamp results instead of wrapping on overflow.
module cordic_xy_step
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int SH_W   = 3
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic        [SH_W-1:0]   shift_i,
  input  logic                     dir_i,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] y_o
);

  logic signed [DATA_W-1:0] xs;
  logic signed [DATA_W-1:0] ys;

`ifdef CORDIC_XY_SAT_EN
  logic signed [DATA_W:0] xw;
  logic signed [DATA_W:0] yw;

  // One guard bit is enough: a single add of two DATA_W values cannot exceed it.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1])
      sat = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat = v[DATA_W-1:0];
  endfunction

  always_comb begin
    xs = x_i >>> shift_i;
    ys = y_i >>> shift_i;
    if (dir_i == DIR_POS) begin
      xw = (DATA_W+1)'(x_i) - (DATA_W+1)'(ys);
      yw = (DATA_W+1)'(y_i) + (DATA_W+1)'(xs);
    end else begin
      xw = (DATA_W+1)'(x_i) + (DATA_W+1)'(ys);
      yw = (DATA_W+1)'(y_i) - (DATA_W+1)'(xs);
    end
    x_o = sat(xw);
    y_o = sat(yw);
  end
`else
  always_comb begin
    xs = x_i >>> shift_i;
    ys = y_i >>> shift_i;
    if (dir_i == DIR_POS) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
    end
  end
`endif

endmodule

// File: rtl/cordic_xy_rotator.sv
// Iterative CORDIC x/y rotator: applies ITER direction bits to (K_INIT, 0) to yield cos/sin.
// Optional CORDIC_XY_SAT_EN (in cordic_xy_step) selects saturating instead of wrapping adds.
module cordic_xy_rotator
  import cordic_pkg::*;
#(
  parameter int DATA_W = CORDIC_DATA_W,
  parameter int ITER   = CORDIC_ITER,
  parameter int K_INIT = CORDIC_K_INIT
) (
  input logic              CLK,
  input logic              RESET,
  cordic_xy_rotator_if.slave bus
);

  localparam int                       CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]         LAST   = CNT_W'(ITER - 1);
  localparam logic signed [DATA_W-1:0] X_LOAD = DATA_W'(K_INIT);

  cordic_state_e            state_q;
  logic signed [DATA_W-1:0] x_q, y_q;
  logic signed [DATA_W-1:0] x_d, y_d;
  logic [CNT_W-1:0]         i_q;
  logic                     busy_q, done_q;

  cordic_xy_step #(
    .DATA_W (DATA_W),
    .SH_W   (CNT_W)
  ) u_step (
    .x_i     (x_q),
    .y_i     (y_q),
    .shift_i (i_q),
    .dir_i   (bus.DIR),
    .x_o     (x_d),
    .y_o     (y_d)
  );

  // START outranks any step presented in the same cycle, in every state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.START) begin
      state_q <= RUN;
      x_q     <= X_LOAD;
      y_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.STEP_VALID) begin
            x_q <= x_d;
            y_q <= y_d;
            if (i_q == LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.COS  = x_q;
  assign bus.SIN  = y_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_cordic_xy_rotator.sv
// Directed bench for cordic_xy_rotator: per-cycle check against an integer model plus literal trajectories.
module tb_cordic_xy_rotator;

  localparam int DW   = 10;
  localparam int NIT  = 8;
  localparam int KI   = 155;
  localparam int HALF = 1 << (DW - 1);

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cordic_xy_rotator_if #(.DATA_W(DW)) bus  ();
  cordic_xy_rotator_if #(.DATA_W(DW)) bus2 ();

  cordic_xy_rotator #(.DATA_W(DW), .ITER(NIT), .K_INIT(KI)) u_dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  cordic_xy_rotator #(.DATA_W(DW), .ITER(NIT), .K_INIT(500)) u_dut_k (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  int mx = 0, my = 0, mi = 0;
  int mphase = 0;  // 0 idle, 1 running, 2 finished

  int exp_x [NIT] = '{155, 78, 20, -11, -26, -33, -36, -37};
  int exp_y [NIT] = '{155, 232, 251, 253, 252, 251, 250, 249};

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Floor division by 2^s, written without shifts.
  function automatic int fshr(input int v, input int s);
    int p;
    p = 1;
    for (int k = 0; k < s; k++) p = p * 2;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  function automatic int fit(input int v);
`ifdef CORDIC_XY_SAT_EN
    if (v > HALF - 1) return HALF - 1;
    if (v < -HALF) return -HALF;
    return v;
`else
    int m;
    m = ((v % (2 * HALF)) + 2 * HALF) % (2 * HALF);
    return (m >= HALF) ? m - 2 * HALF : m;
`endif
  endfunction

  always @(posedge clk) begin
    int nx, ny;
    if (!rst_n) begin
      mx = 0; my = 0; mi = 0; mphase = 0;
    end else if (bus.START) begin
      mx = KI; my = 0; mi = 0; mphase = 1;
    end else if (mphase == 1 && bus.STEP_VALID) begin
      if (bus.DIR) begin
        nx = mx + fshr(my, mi);
        ny = my - fshr(mx, mi);
      end else begin
        nx = mx - fshr(my, mi);
        ny = my + fshr(mx, mi);
      end
      mx = fit(nx);
      my = fit(ny);
      if (mi == NIT - 1) mphase = 2;
      else mi = mi + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_cos",  int'(bus.COS), mx);
      chk("model_sin",  int'(bus.SIN), my);
      chk("model_busy", int'(bus.BUSY), (mphase == 1) ? 1 : 0);
      chk("model_done", int'(bus.DONE), (mphase == 2) ? 1 : 0);
    end
  end

  task automatic cyc(input logic st, input logic sv, input logic d);
    bus.START      = st;
    bus.STEP_VALID = sv;
    bus.DIR        = d;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.START = 1'b0;  bus.STEP_VALID = 1'b0;  bus.DIR = 1'b0;
    bus2.START = 1'b0; bus2.STEP_VALID = 1'b0; bus2.DIR = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    chk("reset_cos",  int'(bus.COS), 0);
    chk("reset_sin",  int'(bus.SIN), 0);
    chk("reset_busy", int'(bus.BUSY), 0);
    chk("reset_done", int'(bus.DONE), 0);

    cyc(0, 1, 0);
    chk("idle_step_ignored", int'(bus.COS), 0);

    // Eight back-to-back positive rotations
    cyc(1, 0, 0);
    chk("load_cos",  int'(bus.COS), 155);
    chk("load_busy", int'(bus.BUSY), 1);
    for (int k = 0; k < NIT; k++) begin
      cyc(0, 1, 0);
      chk("traj_cos", int'(bus.COS), exp_x[k]);
      chk("traj_sin", int'(bus.SIN), exp_y[k]);
      chk("traj_done", int'(bus.DONE), (k == NIT - 1) ? 1 : 0);
    end
    chk("end_busy", int'(bus.BUSY), 0);
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    chk("done_hold_cos", int'(bus.COS), -37);
    chk("done_hold_sin", int'(bus.SIN), 249);

    // Same run with a one-cycle gap after every step
    cyc(1, 0, 0);
    for (int k = 0; k < NIT; k++) begin
      cyc(0, 1, 0);
      chk("gap_cos", int'(bus.COS), exp_x[k]);
      chk("gap_done", int'(bus.DONE), (k == NIT - 1) ? 1 : 0);
      cyc(0, 0, 1);
      chk("gap_hold_cos", int'(bus.COS), exp_x[k]);
      chk("gap_hold_sin", int'(bus.SIN), exp_y[k]);
    end

    // Restart mid-run, with a step presented alongside START
    cyc(1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1);
    cyc(1, 1, 1);
    chk("restart_cos", int'(bus.COS), 155);
    chk("restart_sin", int'(bus.SIN), 0);
    for (int k = 0; k < NIT; k++) cyc(0, 1, 0);
    chk("restart_final_cos", int'(bus.COS), -37);
    chk("restart_final_sin", int'(bus.SIN), 249);
    chk("restart_final_done", int'(bus.DONE), 1);

    // Reset aborts a run
    cyc(1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0);
    rst_n = 1'b1;
    chk("abort_cos",  int'(bus.COS), 0);
    chk("abort_sin",  int'(bus.SIN), 0);
    chk("abort_busy", int'(bus.BUSY), 0);
    chk("abort_done", int'(bus.DONE), 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0);
    chk("abort_idle_cos", int'(bus.COS), 0);

    // Random directions and random gaps, checked by the model each cycle
    for (int r = 0; r < 6; r++) begin
      cyc(1, 0, 0);
      for (int k = 0; k < NIT; k++) begin
        while ($urandom_range(0, 2) == 0) cyc(0, 0, 1'($urandom_range(0, 1)));
        cyc(0, 1, 1'($urandom_range(0, 1)));
      end
      chk("rand_done", int'(bus.DONE), 1);
      cyc(0, 1, 1);
    end

    // Overflow case on the K_INIT=500 instance
    bus2.START = 1'b1;
    @(negedge clk);
    bus2.START = 1'b0;
    bus2.STEP_VALID = 1'b1;
    @(negedge clk);
    chk("k500_s0_cos", int'(bus2.COS), 500);
    chk("k500_s0_sin", int'(bus2.SIN), 500);
    @(negedge clk);
    bus2.STEP_VALID = 1'b0;
    chk("k500_s1_cos", int'(bus2.COS), 250);
`ifdef CORDIC_XY_SAT_EN
    chk("k500_s1_sin", int'(bus2.SIN), 511);
`else
    chk("k500_s1_sin", int'(bus2.SIN), -274);
`endif
    @(negedge clk);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
